delta_encoder: RTL and testbench
================================

DELTA_ENCODER -- requirements
Module: delta_encoder

Interface
REQ-001 The block SHALL be parameterised as follows (name, default, meaning):
- DATA_WIDTH, parameters::DATA_WIDTH, input sample width W.
- NUM_CH, 4, number of interleaved channels (>=2); CH_W = $clog2(NUM_CH).
- KEY_INTERVAL, 16, accepted beats per channel between forced keyframes; 0 disables periodic keyframes.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst_n, in, 1, reset, synchronous, active-low.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, block can accept a beat.
- in_data, in, W, unsigned sample.
- in_ch, in, CH_W, channel tag.
- mode, in, 2, 00 passthrough, 01 delta, 10 delta+zigzag, 11 reserved (treated as 01).
- clear, in, 1, one-cycle pulse that clears all channel history.
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, downstream accepts.
- out_data, out, W+1, encoded word.
- out_ch, out, CH_W, channel tag of out_data.
- out_key, out, 1, out_data is a raw (key) sample.
- out_err, out, 1, the beat's in_ch was >= NUM_CH.

Function
REQ-003 A beat SHALL be accepted when in_valid and in_ready are both 1; an output beat SHALL complete when out_valid and out_ready are both 1.
REQ-004 The output SHALL be a single register stage with in_ready = !out_valid || out_ready (combinational); latency from acceptance to out_valid SHALL be exactly 1 cycle.
REQ-005 While out_valid=1 and out_ready=0, out_data, out_ch, out_key and out_err SHALL hold stable.
REQ-006 Each channel SHALL hold prev[W-1:0], a seen bit and cnt (counting 0..KEY_INTERVAL-1).
REQ-007 An accepted beat SHALL be a key when mode=00, when the channel's seen=0, or when KEY_INTERVAL>0 and cnt=0.
REQ-008 A key beat SHALL output out_data = {1'b0, in_data} with out_key=1.
REQ-009 Delta SHALL be d = in_data - prev, computed as a (W+1)-bit two's-complement value (range -(2^W-1)..+(2^W-1)) with no saturation.
REQ-010 In mode 01/11, non-key beats SHALL output out_data = d with out_key=0.
REQ-011 In mode 10, non-key beats SHALL output out_data = zigzag(d) = (d<<1) ^ {(W+1){d[W]}}, truncated to W+1 bits, with out_key=0.
REQ-012 Every accepted in-range beat, in any mode, SHALL set prev=in_data and seen=1, and SHALL advance cnt modulo KEY_INTERVAL (cnt is held at 0 when KEY_INTERVAL=0).
REQ-013 A beat with in_ch >= NUM_CH SHALL output raw data with out_key=1 and out_err=1 and SHALL NOT modify any channel state; out_ch SHALL carry in_ch truncated to CH_W bits.
REQ-014 clear SHALL set seen=0 and cnt=0 for all channels in that cycle and SHALL NOT affect the output register or pending handshakes.
REQ-015 When clear coincides with an accepted beat, that beat SHALL be encoded as a key, and its channel's state SHALL be updated by the beat (seen=1, cnt=1 mod KEY_INTERVAL).
REQ-016 mode SHALL be sampled per accepted beat; a mode change SHALL NOT clear history.

Reset
REQ-017 When rst_n=0 at a clock edge, the block SHALL set out_valid=0, out_data=0, out_ch=0, out_key=0, out_err=0, and all seen=0 and cnt=0; prev values are don't-care.
REQ-018 While rst_n=0, in_ready SHALL be 0, and any in-flight output beat SHALL be discarded.
REQ-019 The first beat on each channel after reset SHALL be a key.

Verification (W=8, NUM_CH=2, KEY_INTERVAL=4)
REQ-020 Delta, mode 01: ch0 inputs 10, 12, 9 SHALL produce 0x00A key=1, then 0x002, then 0x1FD (-3), with key=0 for both.
REQ-021 Zigzag, mode 10: the same inputs after reset SHALL produce 0x00A key=1, then 0x004, then 0x005.
REQ-022 Extremes, mode 01: ch1 inputs 0, 255, 0 SHALL produce 0x000 key=1, then 0x0FF, then 0x101 (-255).
REQ-023 Interleave and keyframes: ch0 inputs 1..6 interleaved with ch1 inputs 100..105 SHALL mark ch0 beats 1 and 5 and ch1 beats 100 and 104 key=1, with each channel's delta = +1 otherwise.
REQ-024 Backpressure: with out_ready held 0 for 3 cycles during streaming, in_ready SHALL be 0, the outputs SHALL hold, and all beats SHALL be delivered in order with none lost or duplicated.
REQ-025 Reset and error handling: asserting rst_n=0 mid-stream SHALL clear out_valid the next cycle, and the next ch0 beat SHALL be a key. An in_ch=3 beat (with CH_W widened by the test) SHALL set out_err=1 and leave the state of ch0 and ch1 unchanged.

Source files
------------

// File: rtl/delta_encoder.sv
// -----------------------------------------------------------------------------
// delta_encoder
//   Per-channel delta encoder for an interleaved sample stream. Each channel
//   keeps its last sample (prev), a seen flag and a keyframe counter. Beats are
//   emitted raw (key) or as a (W+1)-bit two's-complement delta, optionally
//   zigzag-mapped so small magnitudes become small unsigned codes.
//
//   Handshake: a beat transfers on any rising edge where valid && ready.
//   The producer holds valid and its payload until that edge, and the
//   consumer may change ready at any time. The output is one register
//   stage: in_ready = rst_n && (!out_valid || out_ready), and the payload
//   is frozen while out_valid && !out_ready.
//
// Ports
//   clk, rst_n         : clock, synchronous active-low reset
//   in_valid/in_ready  : input handshake
//   in_data, in_ch     : unsigned sample and its channel tag
//   mode               : 00 passthrough, 01 delta, 10 delta+zigzag, 11 = 01
//   clear              : one-cycle pulse that wipes all channel history
//   out_valid/out_ready: output handshake
//   out_data           : encoded word (W+1 bits)
//   out_ch             : channel tag of out_data
//   out_key            : out_data is a raw sample
//   out_err            : the beat's channel tag was out of range
// -----------------------------------------------------------------------------
package parameters;
  localparam int DATA_WIDTH = 8;
endpackage

module delta_encoder #(
  parameter int DATA_WIDTH   = parameters::DATA_WIDTH,
  parameter int NUM_CH       = 4,
  parameter int KEY_INTERVAL = 16,
  // Normally derived; may be widened so out-of-range tags are expressible.
  parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CH_W-1:0]       in_ch,
  input  logic [1:0]            mode,
  input  logic                  clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic                  out_key,
  output logic                  out_err
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = (KEY_INTERVAL > 1) ? $clog2(KEY_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    (KEY_INTERVAL > 0) ? CNT_W'(KEY_INTERVAL - 1) : '0;
  localparam logic [CH_W:0] NUM_CH_EXT = (CH_W + 1)'(NUM_CH);

  // Channel history
  logic [W-1:0]     prev_q [NUM_CH];
  logic [NUM_CH-1:0] seen_q;
  logic [CNT_W-1:0] cnt_q  [NUM_CH];

  // Combinational datapath
  logic             accept;
  logic             ch_err;
  logic [W-1:0]     sel_prev;
  logic             sel_seen;
  logic [CNT_W-1:0] sel_cnt;
  logic             base_seen;
  logic [CNT_W-1:0] base_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             is_key;
  logic [W:0]       delta;
  logic [W:0]       zigzag;
  logic [W:0]       enc;

  assign in_ready = rst_n && (!out_valid || out_ready);

  always_comb begin
    accept   = in_valid && in_ready;
    ch_err   = ({1'b0, in_ch} >= NUM_CH_EXT);
    sel_prev = '0;
    sel_seen = 1'b0;
    sel_cnt  = '0;
    // Loop-compare select avoids indexing the arrays with a tag that may be
    // wider than (or out of range for) the channel count.
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_ch == CH_W'(i)) begin
        sel_prev = prev_q[i];
        sel_seen = seen_q[i];
        sel_cnt  = cnt_q[i];
      end
    end
    // A coincident clear makes the beat see freshly-cleared history.
    base_seen = sel_seen && !clear;
    base_cnt  = clear ? '0 : sel_cnt;
    is_key    = ch_err || (mode == 2'b00) || !base_seen ||
                ((KEY_INTERVAL > 0) && (base_cnt == '0));
    if ((KEY_INTERVAL == 0) || (base_cnt == CNT_MAX)) cnt_next = '0;
    else                                              cnt_next = base_cnt + 1'b1;
    // Wrap-around subtraction in W+1 bits gives the exact signed difference.
    delta  = {1'b0, in_data} - {1'b0, sel_prev};
    zigzag = {delta[W-1:0], 1'b0} ^ {(W + 1){delta[W]}};
    if (is_key)               enc = {1'b0, in_data};
    else if (mode == 2'b10)   enc = zigzag;
    else                      enc = delta;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_key   <= 1'b0;
      out_err   <= 1'b0;
      seen_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= enc;
        out_ch    <= in_ch;
        out_key   <= is_key;
        out_err   <= ch_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (clear) begin
          seen_q[i] <= 1'b0;
          cnt_q[i]  <= '0;
        end
        // Later assignment wins, so a beat landing with clear updates its channel.
        if (accept && !ch_err && (in_ch == CH_W'(i))) begin
          prev_q[i] <= in_data;
          seen_q[i] <= 1'b1;
          cnt_q[i]  <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_delta_encoder.sv
// -----------------------------------------------------------------------------
// tb_delta_encoder
//   Directed bench for delta_encoder with W=8, NUM_CH=2, KEY_INTERVAL=4 and a
//   2-bit channel tag so an out-of-range tag (3) can be driven.
// -----------------------------------------------------------------------------
module tb_delta_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_ch;
  logic [1:0] mode;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic [1:0] out_ch;
  logic       out_key;
  logic       out_err;

  int checks = 0;
  int errors = 0;

  delta_encoder #(
    .DATA_WIDTH  (8),
    .NUM_CH      (2),
    .KEY_INTERVAL(4),
    .CH_W        (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ch    (in_ch),
    .mode     (mode),
    .clear    (clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_key  (out_key),
    .out_err  (out_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Driver: present one beat, wait (bounded) for acceptance, capture outputs.
  task automatic drive_beat(input logic [1:0] ch, input logic [7:0] data,
                            input logic [1:0] md, input logic clr,
                            output logic [8:0] o_data, output logic o_key,
                            output logic o_err, output logic [1:0] o_ch,
                            output logic o_valid);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_ch = ch; in_data = data; mode = md; clear = clr;
    #1;
    while (!in_ready && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout ch=%0d data=%0d in_ready stayed 0", ch, data);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    o_data = out_data; o_key = out_key; o_err = out_err; o_ch = out_ch; o_valid = out_valid;
  endtask

  logic [8:0] od;
  logic       ok, oe, ov;
  logic [1:0] oc;

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_ch, out_key, out_err} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h ch=%0d k=%b e=%b want all 0",
               out_valid, out_data, out_ch, out_key, out_err);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_delta();
    logic [7:0] din  [4];
    logic [8:0] dexp [4];
    logic       kexp [4];
    logic [1:0] mds  [4];
    din  = '{8'd10, 8'd12, 8'd9, 8'd10};
    dexp = '{9'h00A, 9'h002, 9'h1FD, 9'h001};
    kexp = '{1'b1, 1'b0, 1'b0, 1'b0};
    mds  = '{2'b01, 2'b01, 2'b01, 2'b11};  // last beat: reserved mode acts as delta
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_beat(2'd0, din[i], mds[i], 1'b0, od, ok, oe, oc, ov);
      checks++;
      if (od !== dexp[i] || ok !== kexp[i] || oe !== 1'b0 || ov !== 1'b1) begin
        errors++;
        $display("FAIL delta[%0d] got d=%h k=%b e=%b v=%b want d=%h k=%b e=0 v=1",
                 i, od, ok, oe, ov, dexp[i], kexp[i]);
      end
    end
  endtask

  task automatic test_zigzag();
    logic [7:0] din  [3];
    logic [8:0] dexp [3];
    din  = '{8'd10, 8'd12, 8'd9};
    dexp = '{9'h00A, 9'h004, 9'h005};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_beat(2'd0, din[i], 2'b10, 1'b0, od, ok, oe, oc, ov);
      checks++;
      if (od !== dexp[i] || ok !== (i == 0)) begin
        errors++;
        $display("FAIL zigzag[%0d] got d=%h k=%b want d=%h k=%b", i, od, ok, dexp[i], (i == 0));
      end
    end
  endtask

  task automatic test_extremes();
    logic [7:0] din  [3];
    logic [8:0] dexp [3];
    din  = '{8'd0, 8'd255, 8'd0};
    dexp = '{9'h000, 9'h0FF, 9'h101};
    for (int i = 0; i < 3; i++) begin
      drive_beat(2'd1, din[i], 2'b01, 1'b0, od, ok, oe, oc, ov);
      checks++;
      if (od !== dexp[i] || ok !== (i == 0) || oc !== 2'd1) begin
        errors++;
        $display("FAIL extremes[%0d] got d=%h k=%b ch=%0d want d=%h k=%b ch=1",
                 i, od, ok, oc, dexp[i], (i == 0));
      end
    end
  endtask

  task automatic test_interleave();
    logic [7:0] d;
    logic [8:0] de;
    logic       ke;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 2; c++) begin
        d  = (c == 0) ? 8'(1 + k) : 8'(100 + k);
        ke = (k == 0 || k == 4);
        de = ke ? {1'b0, d} : 9'h001;
        drive_beat(2'(c), d, 2'b01, 1'b0, od, ok, oe, oc, ov);
        checks++;
        if (od !== de || ok !== ke || oc !== 2'(c)) begin
          errors++;
          $display("FAIL interleave ch%0d beat%0d got d=%h k=%b ch=%0d want d=%h k=%b",
                   c, k, od, ok, oc, de, ke);
        end
      end
    end
  endtask

  task automatic test_passthrough();
    // Channel 0 already has history; passthrough still emits raw keys.
    drive_beat(2'd0, 8'd50, 2'b00, 1'b0, od, ok, oe, oc, ov);
    checks++;
    if (od !== 9'h032 || ok !== 1'b1) begin
      errors++; $display("FAIL passthrough got d=%h k=%b want d=032 k=1", od, ok);
    end
    // Mode change keeps history: next delta is relative to 50.
    drive_beat(2'd0, 8'd53, 2'b01, 1'b0, od, ok, oe, oc, ov);
    checks++;
    if (od !== 9'h003 || ok !== 1'b0) begin
      errors++; $display("FAIL mode_switch got d=%h k=%b want d=003 k=0", od, ok);
    end
  endtask

  task automatic test_clear();
    logic [8:0] dexp [5];
    logic       kexp [5];
    do_reset();
    drive_beat(2'd0, 8'd5, 2'b01, 1'b0, od, ok, oe, oc, ov);
    drive_beat(2'd0, 8'd6, 2'b01, 1'b0, od, ok, oe, oc, ov);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    drive_beat(2'd0, 8'd7, 2'b01, 1'b0, od, ok, oe, oc, ov);
    checks++;
    if (od !== 9'h007 || ok !== 1'b1) begin
      errors++; $display("FAIL clear_alone got d=%h k=%b want d=007 k=1", od, ok);
    end
    // Clear coincident with a beat: key, then cnt restarts at 1.
    dexp = '{9'h014, 9'h001, 9'h001, 9'h001, 9'h018};
    kexp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive_beat(2'd0, 8'(20 + i), 2'b01, (i == 0), od, ok, oe, oc, ov);
      checks++;
      if (od !== dexp[i] || ok !== kexp[i]) begin
        errors++;
        $display("FAIL clear_with_beat[%0d] got d=%h k=%b want d=%h k=%b",
                 i, od, ok, dexp[i], kexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_q[$];
    logic [8:0] held;
    int sent, got, cyc;
    do_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 4 == 0) ? 9'(30 + i) : 9'h001);
    sent = 0; got = 0; cyc = 0;
    held = '0;
    mode = 2'b01; in_ch = 2'd0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      in_valid  = (sent < 8);
      in_data   = 8'(30 + sent);
      out_ready = !(cyc >= 3 && cyc < 6);
      #1;
      if (!out_ready && out_valid) begin
        if (cyc == 3) held = out_data;
        checks++;
        if (in_ready !== 1'b0 || out_data !== held) begin
          errors++;
          $display("FAIL stall cyc%0d got in_ready=%b d=%h want in_ready=0 d=%h",
                   cyc, in_ready, out_data, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
          errors++;
          $display("FAIL stream beat%0d got d=%h want d=%h", got, out_data,
                   (exp_q.size() != 0) ? exp_q[0] : 9'h0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_count got %0d delivered, %0d left want 8, 0", got, exp_q.size());
    end
  endtask

  task automatic test_error();
    do_reset();
    drive_beat(2'd0, 8'd10, 2'b01, 1'b0, od, ok, oe, oc, ov);
    drive_beat(2'd1, 8'd50, 2'b01, 1'b0, od, ok, oe, oc, ov);
    drive_beat(2'd3, 8'd77, 2'b01, 1'b0, od, ok, oe, oc, ov);
    checks++;
    if (od !== 9'h04D || ok !== 1'b1 || oe !== 1'b1 || oc !== 2'd3) begin
      errors++;
      $display("FAIL err_beat got d=%h k=%b e=%b ch=%0d want d=04D k=1 e=1 ch=3",
               od, ok, oe, oc);
    end
    drive_beat(2'd0, 8'd11, 2'b01, 1'b0, od, ok, oe, oc, ov);
    checks++;
    if (od !== 9'h001 || ok !== 1'b0 || oe !== 1'b0) begin
      errors++; $display("FAIL err_ch0_intact got d=%h k=%b e=%b want d=001 k=0 e=0", od, ok, oe);
    end
    drive_beat(2'd1, 8'd52, 2'b01, 1'b0, od, ok, oe, oc, ov);
    checks++;
    if (od !== 9'h002 || ok !== 1'b0 || oe !== 1'b0) begin
      errors++; $display("FAIL err_ch1_intact got d=%h k=%b e=%b want d=002 k=0 e=0", od, ok, oe);
    end
  endtask

  task automatic test_reset_midstream();
    drive_beat(2'd0, 8'd40, 2'b01, 1'b0, od, ok, oe, oc, ov);
    drive_beat(2'd0, 8'd41, 2'b01, 1'b0, od, ok, oe, oc, ov);
    @(negedge clk);
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_in_ready got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_out_valid got %b want 0", out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    drive_beat(2'd0, 8'd42, 2'b01, 1'b0, od, ok, oe, oc, ov);
    checks++;
    if (od !== 9'h02A || ok !== 1'b1) begin
      errors++; $display("FAIL midreset_key got d=%h k=%b want d=02A k=1", od, ok);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ch = '0;
    mode = 2'b01; clear = 1'b0; out_ready = 1'b1;
    test_reset();
    test_delta();
    test_zigzag();
    test_extremes();
    test_interleave();
    test_passthrough();
    test_clear();
    test_back_to_back();
    test_error();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
